// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    localparam int LAT_CNT_W = 4;

endpackage : mem_arb_pkg

// File: rtl/arb_starve_ctr.sv
// Grant decision between fetch and data ports, with a starvation count that
// forces a fetch grant after STARVE_MAX consecutive contested data grants.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                 if_req_i,
    input  logic                 d_req_i,
    input  logic [LAT_CNT_W-1:0] starve_cnt_i,
    output grant_t               grant_o,
    output logic [LAT_CNT_W-1:0] starve_cnt_o
);

    localparam logic [LAT_CNT_W-1:0] STARVE_LIMIT = LAT_CNT_W'(STARVE_MAX);

    always_comb begin
        grant_o      = GNT_D;
        starve_cnt_o = starve_cnt_i;
        if (if_req_i && d_req_i) begin
            if (starve_cnt_i < STARVE_LIMIT) begin
                grant_o      = GNT_D;
                starve_cnt_o = starve_cnt_i + 1'b1;
            end else begin
                grant_o      = GNT_IF;
                starve_cnt_o = '0;
            end
        end else if (d_req_i) begin
            grant_o      = GNT_D;
            starve_cnt_o = '0;
        end else if (if_req_i) begin
            grant_o      = GNT_IF;
            starve_cnt_o = '0;
        end
    end

endmodule : arb_starve_ctr

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data ports: one access
// at a time, held for MEM_LATENCY cycles, then a one-cycle ack to the winner.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: MEM_LATENCY must be in 1..15");
    end
    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
        $error("mem_port_arbiter: STARVE_MAX must be in 1..15");
    end

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(MEM_LATENCY - 1);

    state_t               state_q,      state_d;
    grant_t               grant_q,      grant_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q,    lat_cnt_d;
    logic [LAT_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                 we_q,         we_d;
    logic [ADDR_W-1:0]    addr_q,       addr_d;
    logic [DATA_W-1:0]    wdata_q,      wdata_d;
    logic [DATA_W-1:0]    if_rdata_q,   if_rdata_d;
    logic [DATA_W-1:0]    d_rdata_q,    d_rdata_d;

    grant_t               arb_grant;
    logic [LAT_CNT_W-1:0] arb_starve_cnt;

    arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve (
        .if_req_i     (if_req),
        .d_req_i      (d_req),
        .starve_cnt_i (starve_cnt_q),
        .grant_o      (arb_grant),
        .starve_cnt_o (arb_starve_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= GNT_IF;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_d      = arb_grant;
                    starve_cnt_d = arb_starve_cnt;
                    lat_cnt_d    = LAT_LOAD;
                    state_d      = ACCESS;
                    if (arb_grant == GNT_D) begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end else begin
                        addr_d  = if_addr;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (lat_cnt_q == '0) begin
                    state_d = DONE;
                    // Stores leave both read-data registers untouched.
                    if (!we_q) begin
                        if (grant_q == GNT_D) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes and acks decode straight from registered state, so an async
    // reset drops them in the same instant.
    assign mem_read  = (state_q == ACCESS) && !we_q;
    assign mem_write = (state_q == ACCESS) &&  we_q;
    assign if_ack    = (state_q == DONE) && (grant_q == GNT_IF);
    assign d_ack     = (state_q == DONE) && (grant_q == GNT_D);
    assign busy      = (state_q != IDLE);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: instance A runs MEM_LATENCY=1, instance B MEM_LATENCY=3,
// each attached to a small word-addressed memory model.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Instance A signals (MEM_LATENCY = 1)
    logic        if_req_a = 0, d_req_a = 0, d_we_a = 0;
    logic [31:0] if_addr_a = 0, d_addr_a = 0, d_wdata_a = 0;
    logic        if_ack_a, d_ack_a, mem_read_a, mem_write_a, busy_a;
    logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;

    // Instance B signals (MEM_LATENCY = 3)
    logic        if_req_b = 0, d_req_b = 0, d_we_b = 0;
    logic [31:0] if_addr_b = 0, d_addr_b = 0, d_wdata_b = 0;
    logic        if_ack_b, d_ack_b, mem_read_b, mem_write_b, busy_b;
    logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_a), .if_addr(if_addr_a), .if_ack(if_ack_a), .if_rdata(if_rdata_a),
        .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
        .d_ack(d_ack_a), .d_rdata(d_rdata_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a), .mem_read(mem_read_a),
        .mem_write(mem_write_a), .mem_rdata(mem_rdata_a), .busy(busy_a)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b), .if_rdata(if_rdata_b),
        .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
        .d_ack(d_ack_b), .d_rdata(d_rdata_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .mem_rdata(mem_rdata_b), .busy(busy_b)
    );

    assign mem_rdata_a = mem_a[mem_addr_a[9:2]];
    assign mem_rdata_b = mem_b[mem_addr_b[9:2]];

    always @(posedge clk) begin
        if (mem_write_a) mem_a[mem_addr_a[9:2]] <= mem_wdata_a;
        if (mem_write_b) mem_b[mem_addr_b[9:2]] <= mem_wdata_b;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        if_req_a = 0; d_req_a = 0; d_we_a = 0;
        if_req_b = 0; d_req_b = 0; d_we_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int d_cyc, i_cyc, n_acks, overlap, c;
        logic [31:0] got_d [0:9];

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0;
        end
        mem_a[1]  = 32'h2008_0005;
        mem_b[16] = 32'h1234_5678;
        mem_b[17] = 32'hCAFE_0001;

        // Reset state
        do_reset();
        chk("rst_busy_a",   {31'b0, busy_a}, 32'h0);
        chk("rst_acks_a",   {30'b0, if_ack_a, d_ack_a}, 32'h0);
        chk("rst_strobe_a", {30'b0, mem_read_a, mem_write_a}, 32'h0);
        chk("rst_mem_addr_a", mem_addr_a, 32'h0);
        chk("rst_if_rdata_a", if_rdata_a, 32'h0);
        chk("rst_d_rdata_b",  d_rdata_b, 32'h0);

        // Both requests from reset: data first, fetch MEM_LATENCY+2 later
        if_req_a = 1; if_addr_a = 32'h4;
        d_req_a = 1; d_we_a = 0; d_addr_a = 32'h100;
        d_cyc = -1; i_cyc = -1; overlap = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (if_ack_a && d_ack_a) overlap++;
            if (d_ack_a && d_cyc < 0) begin d_cyc = k; d_req_a = 0; end
            if (if_ack_a && i_cyc < 0) begin i_cyc = k; if_req_a = 0; end
        end
        chk("both_d_ack_cycle",  d_cyc, 32'd2);
        chk("both_if_ack_cycle", i_cyc, 32'd5);
        chk("both_ack_gap",      i_cyc - d_cyc, 32'd3);
        chk("both_no_overlap",   overlap, 32'd0);

        // Single fetch, MEM_LATENCY=1
        do_reset();
        if_req_a = 1; if_addr_a = 32'h0000_0004;
        tick();
        chk("if_mem_read",  {31'b0, mem_read_a}, 32'h1);
        chk("if_mem_addr",  mem_addr_a, 32'h4);
        chk("if_ack_early", {31'b0, if_ack_a}, 32'h0);
        tick();
        chk("if_ack",       {31'b0, if_ack_a}, 32'h1);
        chk("if_rdata",     if_rdata_a, 32'h2008_0005);
        chk("if_read_off",  {31'b0, mem_read_a}, 32'h0);
        if_req_a = 0;
        tick();
        chk("if_ack_pulse", {31'b0, if_ack_a}, 32'h0);
        chk("if_idle",      {31'b0, busy_a}, 32'h0);

        // Store then load back
        d_req_a = 1; d_we_a = 1; d_addr_a = 32'h100; d_wdata_a = 32'hDEAD_BEEF;
        tick();
        chk("st_mem_write", {31'b0, mem_write_a}, 32'h1);
        chk("st_mem_read",  {31'b0, mem_read_a}, 32'h0);
        chk("st_mem_wdata", mem_wdata_a, 32'hDEAD_BEEF);
        tick();
        chk("st_d_ack",     {31'b0, d_ack_a}, 32'h1);
        chk("st_write_off", {31'b0, mem_write_a}, 32'h0);
        chk("st_rdata_hold", d_rdata_a, 32'h0);
        d_req_a = 0;
        tick();
        d_req_a = 1; d_we_a = 0;
        tick();
        chk("ld_mem_read",  {31'b0, mem_read_a}, 32'h1);
        tick();
        chk("ld_d_ack",     {31'b0, d_ack_a}, 32'h1);
        chk("ld_d_rdata",   d_rdata_a, 32'hDEAD_BEEF);
        d_req_a = 0;
        tick();

        // Continuous contention: D,D,D,D,IF repeating
        if_req_a = 1; if_addr_a = 32'h4;
        d_req_a = 1; d_we_a = 0; d_addr_a = 32'h100;
        n_acks = 0; overlap = 0; c = 0;
        while (c < 80 && n_acks < 10) begin
            tick();
            c++;
            if (if_ack_a && d_ack_a) overlap++;
            if (d_ack_a) begin got_d[n_acks] = 32'h1; n_acks++; end
            else if (if_ack_a) begin got_d[n_acks] = 32'h0; n_acks++; end
        end
        if_req_a = 0; d_req_a = 0;
        tick();
        chk("starve_ack_count", n_acks, 32'd10);
        chk("starve_no_overlap", overlap, 32'd0);
        for (int k = 0; k < n_acks && k < 10; k++) begin
            chk($sformatf("starve_grant%0d_is_d", k), got_d[k], (k % 5 == 4) ? 32'h0 : 32'h1);
        end

        // MEM_LATENCY=3 single load
        d_req_b = 1; d_we_b = 0; d_addr_b = 32'h40;
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk($sformatf("l3_read_c%0d", k), {31'b0, mem_read_b}, 32'h1);
            chk($sformatf("l3_addr_c%0d", k), mem_addr_b, 32'h40);
            chk($sformatf("l3_busy_c%0d", k), {31'b0, busy_b}, 32'h1);
            chk($sformatf("l3_noack_c%0d", k), {31'b0, d_ack_b}, 32'h0);
        end
        tick();
        chk("l3_d_ack",    {31'b0, d_ack_b}, 32'h1);
        chk("l3_busy_done", {31'b0, busy_b}, 32'h1);
        chk("l3_read_off", {31'b0, mem_read_b}, 32'h0);
        chk("l3_d_rdata",  d_rdata_b, 32'h1234_5678);
        d_req_b = 0;
        tick();
        chk("l3_idle",     {31'b0, busy_b}, 32'h0);

        // Async reset during the 2nd ACCESS cycle
        d_req_b = 1; d_we_b = 0; d_addr_b = 32'h44;
        tick();
        tick();
        chk("rr_mid_read", {31'b0, mem_read_b}, 32'h1);
        #2;
        rst_n = 1'b0;
        d_req_b = 0;
        #1;
        chk("rr_read_zero",  {31'b0, mem_read_b}, 32'h0);
        chk("rr_busy_zero",  {31'b0, busy_b}, 32'h0);
        chk("rr_addr_zero",  mem_addr_b, 32'h0);
        chk("rr_rdata_zero", d_rdata_b, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        overlap = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (d_ack_b || if_ack_b) overlap++;
        end
        chk("rr_no_ack", overlap, 32'd0);
        d_req_b = 1;
        d_cyc = -1;
        for (int k = 1; k <= 10 && d_cyc < 0; k++) begin
            tick();
            if (d_ack_b) d_cyc = k;
        end
        d_req_b = 0;
        chk("rr_reissue_cycle", d_cyc, 32'd4);
        chk("rr_reissue_rdata", d_rdata_b, 32'hCAFE_0001);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_mem_port_arbiter
